// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves the latched operand one bit per clock in the selected
// mode until the loaded shift count is used up, then pulses done for one cycle.
module seq_shifter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   input  logic [SHW-1:0]   amount,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic [1:0]       dbg_state
);

   // Handshake: start is a request sampled on every rising edge; it is taken only
   // while busy=0 (IDLE or DONE), is ignored while busy=1, and the matching result
   // is valid on the single cycle where done=1 (start may be held to chain ops).
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted;
   logic [SHW-1:0]   cnt;
   logic [1:0]       mode_q;
   logic             accept;

   assign accept = start && (state != SHIFT);

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SHIFT;
         SHIFT:   if (cnt == '0) next_state = DONE;
         DONE:    next_state = start ? SHIFT : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      shifted = shreg;
      case (mode_q)
         MODE_SLL: shifted = {shreg[WIDTH-2:0], 1'b0};
         MODE_SRL: shifted = {1'b0, shreg[WIDTH-1:1]};
         MODE_SRA: shifted = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
         MODE_ROR: shifted = {shreg[0], shreg[WIDTH-1:1]};
         default:  shifted = shreg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         shreg  <= '0;
         cnt    <= '0;
         mode_q <= MODE_SLL;
      end else begin
         state <= next_state;
         if (accept) begin
            shreg  <= data;
            mode_q <= mode;
            cnt    <= amount;
         end else if (state == SHIFT && cnt != '0) begin
            shreg <= shifted;
            cnt   <= cnt - SHW'(1);
         end
      end
   end

   assign result    = shreg;
   assign busy      = (state == SHIFT);
   assign done      = (state == DONE);
   assign zero      = (shreg == '0);
   assign dbg_state = state;

endmodule
